// File: rtl/dice_roller.sv
// Dice roller: on a roll-button release it spins for ROLL_CYCLES cycles, settles on 1..6,
// strobes pulse_o, then holds num until the choose stage returns done_i.
module dice_roller #(
    parameter int unsigned ROLL_CYCLES = 8,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       roll,
    input  logic       enable,
    input  logic       done_i,
    output logic [2:0] num,
    output logic       pulse_o,
    output logic       busy,
    output logic       rolling
);

    // state     | meaning
    // IDLE      | waiting for a press while enabled
    // PRESSED   | button down, waiting for release
    // SPIN      | animation; num follows the LFSR candidate
    // EMIT      | pulse_o strobe, num is final
    // WAIT_DONE | num held until the choose stage finishes the turn
    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESSED,
        S_SPIN,
        S_EMIT,
        S_WAIT_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_lfsr;
    logic [7:0] r_count;
    logic [2:0] r_num;
    logic       r_pulse;
    logic       w_fb;
    logic [2:0] w_cand;
    logic       w_load;
    logic       w_spin_last;

    assign w_fb        = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_cand      = 3'(r_lfsr % 8'd6) + 3'd1;
    assign w_spin_last = (r_state == S_SPIN) && (r_count == 8'd0);

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && roll) w_next = S_PRESSED;
            end
            S_PRESSED: begin
                if (!enable) begin
                    w_next = S_IDLE;
                end else if (!roll) begin
                    w_next = S_SPIN;
                    w_load = 1'b1;
                end
            end
            S_SPIN: begin
                if (r_count == 8'd0) w_next = S_EMIT;
            end
            S_EMIT: begin
                w_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_lfsr  <= LFSR_SEED;
            r_count <= 8'd0;
            r_num   <= 3'd0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_next;
            r_lfsr  <= {r_lfsr[6:0], w_fb};
            if (w_load) begin
                r_count <= 8'(ROLL_CYCLES - 1);
            end else if ((r_state == S_SPIN) && (r_count != 8'd0)) begin
                r_count <= r_count - 8'd1;
            end
            if (r_state == S_SPIN) r_num <= w_cand;
            // Registered strobe lands exactly in the EMIT cycle.
            r_pulse <= w_spin_last;
        end
    end

    assign num     = r_num;
    assign pulse_o = r_pulse;
    assign busy    = (r_state != S_IDLE);
    assign rolling = (r_state == S_SPIN);

endmodule

// File: tb/tb_dice_roller.sv
// Self-checking bench for dice_roller: directed scenarios plus 1000 randomized rolls
// checked against an LFSR/timing reference model.
module tb_dice_roller;

    localparam int RC = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       roll = 1'b0;
    logic       enable = 1'b0;
    logic       done_i = 1'b0;
    logic [2:0] num;
    logic       pulse_o;
    logic       busy;
    logic       rolling;

    int n_tests = 0;
    int n_fail  = 0;

    dice_roller #(.ROLL_CYCLES(RC), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .rst(rst), .roll(roll), .enable(enable), .done_i(done_i),
        .num(num), .pulse_o(pulse_o), .busy(busy), .rolling(rolling)
    );

    always #5 clk = ~clk;

    // Reference LFSR: the value held in each cycle, plus the one from the cycle before.
    logic [7:0] m_lfsr = 8'hA5;
    logic [7:0] m_prev = 8'hA5;
    always @(posedge clk) begin
        m_prev = m_lfsr;
        if (rst) m_lfsr = 8'hA5;
        else     m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic [2:0] face(input logic [7:0] v);
        int t;
        t = (int'(v) % 6) + 1;
        return t[2:0];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Press for press_len edges, release, and observe until two cycles past the strobe.
    task automatic do_roll(input int press_len, output int rc, output int pc, output int lat,
                           output logic [2:0] n, output logic [2:0] exp_n);
        rc = 0; pc = 0; lat = 0; n = 3'd0; exp_n = 3'd7;
        enable = 1'b1;
        roll   = 1'b1;
        repeat (press_len) cyc();
        roll = 1'b0;
        cyc();
        for (int i = 1; i <= 30; i++) begin
            if (rolling) rc++;
            if (pulse_o) begin
                pc++;
                if (pc == 1) begin
                    lat   = i;
                    n     = num;
                    exp_n = face(m_prev);
                end
            end
            if (pc > 0 && i >= lat + 2) break;
            cyc();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_tests++; if (num !== 3'd0) begin n_fail++; $display("FAIL reset_num c%0d got %0d exp 0", k, num); end
            n_tests++; if (pulse_o !== 1'b0) begin n_fail++; $display("FAIL reset_pulse c%0d got %b exp 0", k, pulse_o); end
            n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy c%0d got %b exp 0", k, busy); end
            n_tests++; if (rolling !== 1'b0) begin n_fail++; $display("FAIL reset_rolling c%0d got %b exp 0", k, rolling); end
        end
    endtask

    task automatic test_spin(output logic [2:0] held);
        int rc, pc, lat;
        logic [2:0] n, e;
        do_roll(4, rc, pc, lat, n, e);
        held = n;
        n_tests++; if (rc != RC) begin n_fail++; $display("FAIL spin_rolling_cycles got %0d exp %0d", rc, RC); end
        n_tests++; if (pc != 1) begin n_fail++; $display("FAIL spin_pulse_count got %0d exp 1", pc); end
        n_tests++; if (lat != RC + 1) begin n_fail++; $display("FAIL spin_latency got %0d exp %0d", lat, RC + 1); end
        n_tests++; if (n !== e) begin n_fail++; $display("FAIL spin_num got %0d exp %0d", n, e); end
        n_tests++; if (n < 3'd1 || n > 3'd6) begin n_fail++; $display("FAIL spin_num_range got %0d exp 1..6", n); end
    endtask

    task automatic test_hold(input logic [2:0] held);
        for (int k = 0; k < 20; k++) begin
            roll = 1'($urandom);
            cyc();
            n_tests++; if (num !== held) begin n_fail++; $display("FAIL hold_num c%0d got %0d exp %0d", k, num, held); end
            n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy c%0d got %b exp 1", k, busy); end
            n_tests++; if (pulse_o !== 1'b0) begin n_fail++; $display("FAIL hold_pulse c%0d got %b exp 0", k, pulse_o); end
        end
        roll   = 1'b0;
        done_i = 1'b1;
        cyc();
        done_i = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_done_busy got %b exp 0", busy); end
        cyc();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_enable();
        int rc, pc, lat;
        logic [2:0] n, e;
        enable = 1'b0;
        roll   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) roll = 1'b0;
            cyc();
            n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL en_off_busy c%0d got %b exp 0", k, busy); end
        end
        enable = 1'b1;
        roll   = 1'b1;
        cyc();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL en_pressed_busy got %b exp 1", busy); end
        enable = 1'b0;
        cyc();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL en_drop_busy got %b exp 0", busy); end
        roll = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            n_tests++; if (rolling !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL en_drop_nospin c%0d got rolling=%b busy=%b exp 0 0", k, rolling, busy); end
        end
        // done_i in IDLE must not be remembered for the next turn
        done_i = 1'b1;
        cyc();
        done_i = 1'b0;
        do_roll(2, rc, pc, lat, n, e);
        n_tests++; if (n !== e) begin n_fail++; $display("FAIL en_roll_num got %0d exp %0d", n, e); end
        repeat (3) cyc();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL done_not_latched busy got %b exp 1", busy); end
        done_i = 1'b1;
        cyc();
        done_i = 1'b0;
    endtask

    task automatic test_held_roll();
        int rc, pc, lat;
        logic [2:0] n, e;
        do_roll(1, rc, pc, lat, n, e);
        roll   = 1'b1;
        done_i = 1'b1;
        cyc();
        done_i = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL held_done_idle busy got %b exp 0", busy); end
        cyc();
        n_tests++; if (busy !== 1'b1 || rolling !== 1'b0) begin n_fail++; $display("FAIL held_new_press got busy=%b rolling=%b exp 1 0", busy, rolling); end
        roll = 1'b0;
        cyc();
        n_tests++; if (rolling !== 1'b1) begin n_fail++; $display("FAIL held_spin rolling got %b exp 1", rolling); end
        repeat (RC + 1) cyc();
        done_i = 1'b1;
        cyc();
        done_i = 1'b0;
    endtask

    task automatic test_reset_spin();
        int rc, pc, lat, pulses;
        logic [2:0] n, e;
        enable = 1'b1;
        roll   = 1'b1;
        repeat (2) cyc();
        roll = 1'b0;
        cyc();
        cyc();
        cyc();
        n_tests++; if (rolling !== 1'b1) begin n_fail++; $display("FAIL rstspin_pre rolling got %b exp 1", rolling); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_tests++; if (rolling !== 1'b0) begin n_fail++; $display("FAIL rstspin_rolling got %b exp 0", rolling); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstspin_busy got %b exp 0", busy); end
        n_tests++; if (num !== 3'd0) begin n_fail++; $display("FAIL rstspin_num got %0d exp 0", num); end
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            cyc();
            if (pulse_o === 1'b1) pulses++;
        end
        n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL rstspin_no_pulse got %0d exp 0", pulses); end
        do_roll(3, rc, pc, lat, n, e);
        n_tests++; if (n !== e) begin n_fail++; $display("FAIL rstspin_lfsr_restart num got %0d exp %0d", n, e); end
        done_i = 1'b1;
        cyc();
        done_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        int rc, pc, lat;
        logic [2:0] n, e;
        int seen [1:6];
        int bad_rc, bad_pc, bad_num, bad_rng;
        bad_rc = 0; bad_pc = 0; bad_num = 0; bad_rng = 0;
        for (int v = 1; v <= 6; v++) seen[v] = 0;
        for (int r = 0; r < 1000; r++) begin
            do_roll(int'($urandom_range(1, 3)), rc, pc, lat, n, e);
            if (rc != RC) bad_rc++;
            if (pc != 1) bad_pc++;
            if (n !== e) bad_num++;
            if (n >= 3'd1 && n <= 3'd6) seen[int'(n)]++;
            else bad_rng++;
            done_i = 1'b1;
            cyc();
            done_i = 1'b0;
            repeat ($urandom_range(0, 2)) cyc();
        end
        n_tests++; if (bad_rc != 0) begin n_fail++; $display("FAIL b2b_rolling_cycles bad rolls %0d exp 0", bad_rc); end
        n_tests++; if (bad_pc != 0) begin n_fail++; $display("FAIL b2b_pulse_count bad rolls %0d exp 0", bad_pc); end
        n_tests++; if (bad_num != 0) begin n_fail++; $display("FAIL b2b_num_model bad rolls %0d exp 0", bad_num); end
        n_tests++; if (bad_rng != 0) begin n_fail++; $display("FAIL b2b_num_range bad rolls %0d exp 0", bad_rng); end
        for (int v = 1; v <= 6; v++) begin
            n_tests++; if (seen[v] == 0) begin n_fail++; $display("FAIL b2b_face_seen face %0d count %0d exp >0", v, seen[v]); end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] held;
        test_reset();
        test_spin(held);
        test_hold(held);
        test_enable();
        test_held_roll();
        test_reset_spin();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dice_roller.md
Name: dice_roller

Overview:
Upstream stage of the choose/score stage in the dice game.
- On a debounced roll-button release, runs a short "spin" animation, then settles on a value 1..6.
- Pulses the choose stage with the rolled number.
- Holds that number stable until the choose stage reports the turn complete, then accepts another roll.

Parameters:
ROLL_CYCLES, 8, number of SPIN cycles before the value settles; legal range 1..255.
LFSR_SEED, 8'hA5, LFSR value loaded on reset; must be nonzero.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
roll  input  1  roll button level (already synchronized/debounced), active-high.
enable  input  1  controller permits a new roll; game in play.
done_i  input  1  one-cycle pulse from the choose stage (its pulse_o): turn finished.
num  output  3  rolled value 1..6; 0 after reset until the first spin.
pulse_o  output  1  one-cycle strobe: num is valid; drives choose stage pulse_i.
busy  output  1  high whenever state != IDLE.
rolling  output  1  high during SPIN; used by display for animation.

Behaviour:
Reset values (rst sampled high at posedge):
- state=IDLE, lfsr=LFSR_SEED, count=0, num=0.
- Registered pulse_o=0. Derived outputs follow state: busy=0, rolling=0.
- Reset mid-operation aborts any state; no pulse_o is emitted.

LFSR (8-bit Fibonacci, taps 8,6,5,4):
- Free-runs every non-reset cycle in all states.
- fb = lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]; lfsr <= {lfsr[6:0], fb}.
- Never reaches 0.

Candidate value:
- cand = (lfsr mod 6) + 1, combinational from the current lfsr.
- Result is 3 bits, range 1..6.

State machine:
- IDLE: if enable && roll, go to PRESSED; otherwise stay. done_i is ignored.
- PRESSED: if !enable, go to IDLE. Else if !roll (button released), go to SPIN and set count <= ROLL_CYCLES-1. Else stay.
- SPIN: each cycle num <= cand and rolling=1. If count==0, go to EMIT; else count <= count-1. enable is ignored here. SPIN lasts exactly ROLL_CYCLES cycles.
- EMIT: pulse_o=1 for exactly this one cycle; num unchanged; go to WAIT_DONE.
- WAIT_DONE: num held stable, because the choose stage reads it both in its CHECK state and again at its confirm-release. On done_i, go to IDLE. roll and enable are ignored.

Timing and outputs:
- Latency: the posedge that samples roll=0 in PRESSED enters SPIN. pulse_o is high in the (ROLL_CYCLES+1)th cycle after that edge.
- num changes only during SPIN.
- Simultaneous roll and done_i in WAIT_DONE: go to IDLE only. A new roll requires a fresh press seen in IDLE.
- Button held through WAIT_DONE into IDLE with enable high: treated as a new press (IDLE to PRESSED).
- done_i arriving in any state other than WAIT_DONE is ignored; it is not latched.

Test Plan:
- Reset, then 3 idle cycles: num=0, pulse_o=0, busy=0, rolling=0. LFSR sequence is 0xA5, 0x4A, 0x95 on successive cycles.
- ROLL_CYCLES=8, enable=1:
  - Press roll for 4 cycles, then release.
  - rolling is high for exactly 8 cycles, then pulse_o high for exactly 1 cycle.
  - num equals the scoreboard model (lfsr mod 6)+1 of the final SPIN cycle and lies in 1..6.
- Hold the pulse_o value for 20 cycles without done_i, toggling roll: num constant, busy=1, no second pulse_o. Then pulse done_i: busy=0 next cycle.
- enable=0: press/release roll, gives no state change and busy=0. enable=1, press, drop enable before release: back to IDLE, no spin.
- Assert rst during SPIN (cycle 3 of 8): next cycle state=IDLE, rolling=0, num=0, lfsr=0xA5, no pulse_o ever emitted for that roll.
- 1000 back-to-back rolls with done_i returned 2 cycles after each pulse_o: every num in 1..6, each value observed at least once, exactly one pulse_o per release.
